byte_match_tracker: RTL and testbench
=====================================

# byte_match_tracker

Sequential match-tracking stage built around the 8-bit equality compare. It accepts a byte stream over a valid/ready handshake and compares each byte against a programmed 8-bit key. It keeps a saturating total-match count and a consecutive-match run length, and it flags when the run reaches a programmed length. Results go out through a one-deep registered output with valid/ready, so the stage can drop between a byte source and any downstream event consumer.

## Interface
- `RUN_LEN`, default 4: consecutive matches that raise a run hit; legal range 1..255.
- `CNT_W`, default 16: width of the total-match counter.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `key_load` in 1: load `key_in` as the new key and clear tracking state.
- `key_in` in 8: key value, sampled when `key_load`=1.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: stage accepts a byte this cycle.
- `in_data` in 8: stream byte.
- `out_valid` out 1: result beat is valid.
- `out_ready` in 1: downstream takes the result beat.
- `out_match` out 1: result byte equalled the key (all 8 bits).
- `out_run_hit` out 1: this beat made the run length reach `RUN_LEN`.
- `out_run` out 8: run length after this beat.
- `match_count` out `CNT_W`: total matches since the last key load; live, not tied to the handshake.

## Operation
- FSM states:
  - UNARMED: no key loaded.
  - SEARCH: run is 0.
  - RUN: 0 < run < `RUN_LEN`.
  - LOCKED: run = `RUN_LEN`.
- Reset:
  - state UNARMED, key 0x00, run 0, `match_count` 0.
  - `out_valid`, `out_match`, `out_run_hit`, `out_run` all 0.
- Key load:
  - `key_load`=1 from any state: next state SEARCH, key ← `key_in`, run ← 0, `match_count` ← 0.
  - A pending output beat is kept unchanged.
- Accept rule: `in_ready` = (state≠UNARMED) ∧ ¬`key_load` ∧ (¬`out_valid` ∨ `out_ready`). A beat is accepted when `in_valid` ∧ `in_ready`.
- Per accepted byte, let m = (`in_data` == key):
  - m=1:
    - run ← min(run+1, `RUN_LEN`).
    - `match_count` ← saturating +1; it holds at all-ones.
    - SEARCH→RUN, or →LOCKED if `RUN_LEN`=1.
    - RUN→LOCKED when the new run = `RUN_LEN`.
    - LOCKED stays LOCKED.
  - m=0: run ← 0, next state SEARCH from any armed state.
- `out_run_hit`=1 only on the beat where run changes from `RUN_LEN`−1 to `RUN_LEN`. Further matches while LOCKED give `out_run_hit`=0 with `out_run`=`RUN_LEN`.
- Output register:
  - On accept: load `out_match`, `out_run_hit`, `out_run`; set `out_valid`=1.
  - When `out_valid` ∧ `out_ready` and no new accept: clear `out_valid`.
  - Payload holds stable while `out_valid` ∧ ¬`out_ready`.
- `rst` has priority over `key_load`; `key_load` has priority over stream acceptance.

## Timing
- Latency: a byte accepted at edge t appears as `out_valid`=1 with its result after edge t. `match_count` reflects it after the same edge.
- Full throughput: one byte per cycle while `out_ready`=1.
- Back-pressure: `in_ready` falls in the same cycle that `out_valid`=1 ∧ `out_ready`=0 (combinational from `out_ready`). No skid buffer.
- Key load: `key_load` at edge t forces `in_ready`=0 during that cycle. A byte at t+1 compares against the new key.
- Reset mid-stream: a pending output beat is discarded (`out_valid`=0 after the reset edge) and state returns to UNARMED. `in_ready`=0 until a key is loaded.
- Counter saturation: `match_count` at 2^`CNT_W`−1 stays there on further matches. `out_run` never exceeds `RUN_LEN`.

## Test plan
- Reset, then stream with no key: `in_valid`=1 → `in_ready`=0, `out_valid`=0, all outputs 0.
- Key 0xA5; `out_ready`=1; bytes A5,A5,A5,A5,A5,3C:
  - `out_run` = 1,2,3,4,4,0.
  - `out_run_hit` = 0,0,0,1,0,0.
  - `out_match` = 1,1,1,1,1,0.
  - `match_count`=5.
- Back-pressure: key 0x00, byte 00 accepted, `out_ready`=0 for 3 cycles:
  - `out_valid` holds with `out_match`=1, `out_run`=1.
  - `in_ready`=0 throughout.
  - Next byte accepted in the cycle `out_ready` rises.
- Key reload mid-run: key 0x11; bytes 11,11; then `key_load` with 0x22 asserted together with `in_valid`:
  - byte not accepted that cycle.
  - next byte 22 gives `out_run`=1; `match_count`=1.
- Single-bit discrimination: key 0x80, bytes 0x00, 0x81, 0x80 → `out_match`=0,0,1.
- `CNT_W`=2: five consecutive matches → `match_count` 1,2,3,3,3. Reset during a held output beat → `out_valid`=0 after the reset edge.

Source files
------------

// File: rtl/byte_match_tracker.sv
// Byte stream key-match tracker: counts total matches and consecutive-match runs,
// flags when the run reaches RUN_LEN, and emits one registered result beat per byte.
module byte_match_tracker #(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [7:0]       key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic             out_run_hit,
    output logic [7:0]       out_run,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned BYTE_W  = 8;
    localparam logic [BYTE_W-1:0] RUN_MAX = BYTE_W'(RUN_LEN);

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        SEARCH  = 2'd1,
        RUN     = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    typedef struct packed {
        logic              match;
        logic              run_hit;
        logic [BYTE_W-1:0] run;
    } beat_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  key_q, key_d;
    logic [BYTE_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    beat_t              beat_q, beat_d;

    logic               accept;
    logic               hit;
    logic [BYTE_W-1:0]  run_inc;

    // Ready is combinational from out_ready: no skid buffer behind the result register.
    assign in_ready = (state_q != UNARMED) && !key_load && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign hit      = (in_data == key_q);
    assign run_inc  = (run_q >= RUN_MAX) ? RUN_MAX : run_q + BYTE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNARMED;
            key_q   <= '0;
            run_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            run_q   <= run_d;
            count_q <= count_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        run_d   = run_q;
        count_d = count_q;
        valid_d = valid_q;
        beat_d  = beat_q;

        // A taken beat retires even while a key load is in progress.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (key_load) begin
            state_d = SEARCH;
            key_d   = key_in;
            run_d   = '0;
            count_d = '0;
        end else if (accept) begin
            if (hit) begin
                run_d   = run_inc;
                state_d = (run_inc == RUN_MAX) ? LOCKED : RUN;
                if (!(&count_q)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                run_d   = '0;
                state_d = SEARCH;
            end
            valid_d        = 1'b1;
            beat_d.match   = hit;
            beat_d.run_hit = hit && (run_q != RUN_MAX) && (run_inc == RUN_MAX);
            beat_d.run     = hit ? run_inc : '0;
        end
    end

    assign out_valid   = valid_q;
    assign out_match   = beat_q.match;
    assign out_run_hit = beat_q.run_hit;
    assign out_run     = beat_q.run;
    assign match_count = count_q;

endmodule

// File: tb/tb_byte_match_tracker.sv
// Directed bench for byte_match_tracker: default-parameter instance plus a
// narrow-counter instance for saturation and reset-during-hold.
module tb_byte_match_tracker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, key_load, in_valid, in_ready, out_valid, out_ready;
    logic        out_match, out_run_hit;
    logic [7:0]  key_in, in_data, out_run;
    logic [15:0] match_count;

    // CNT_W=2 instance
    logic        s_rst, s_key_load, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_out_match, s_out_run_hit;
    logic [7:0]  s_key_in, s_in_data, s_out_run;
    logic [1:0]  s_match_count;

    int checks = 0;
    int errors = 0;

    byte_match_tracker #(.RUN_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
        .out_run_hit(out_run_hit), .out_run(out_run), .match_count(match_count)
    );

    byte_match_tracker #(.RUN_LEN(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .key_load(s_key_load), .key_in(s_key_in),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_match(s_out_match),
        .out_run_hit(s_out_run_hit), .out_run(s_out_run), .match_count(s_match_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    // Present one byte, confirm it is accepted, and check the resulting beat.
    task automatic send(input string tag, input logic [7:0] d,
                        input logic m, input logic h, input logic [7:0] r);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_match"}, 32'(out_match), 32'(m));
        check({tag, "_hit"}, 32'(out_run_hit), 32'(h));
        check({tag, "_run"}, 32'(out_run), 32'(r));
    endtask

    logic [7:0] a5_bytes [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C};
    logic [7:0] a5_run   [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd0};
    logic       a5_hit   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       a5_match [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] sat_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] sat_run  [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4};

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_rst = 1'b1; s_key_load = 1'b0; s_key_in = '0; s_in_valid = 1'b0; s_in_data = '0;
        s_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        s_rst = 1'b0;

        // No key loaded: stream is refused.
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check("unarmed_rdy", 32'(in_ready), 32'd0);
        check("unarmed_vld", 32'(out_valid), 32'd0);
        check("unarmed_match", 32'(out_match), 32'd0);
        check("unarmed_hit", 32'(out_run_hit), 32'd0);
        check("unarmed_run", 32'(out_run), 32'd0);
        check("unarmed_cnt", 32'(match_count), 32'd0);
        tick();
        check("unarmed_vld2", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Run up to lock and break it.
        load_key(8'hA5);
        for (int i = 0; i < 6; i++) begin
            send($sformatf("a5_%0d", i), a5_bytes[i], a5_match[i], a5_hit[i], a5_run[i]);
        end
        in_valid = 1'b0;
        check("a5_cnt", 32'(match_count), 32'd5);

        // Back-pressure hold.
        load_key(8'h00);
        check("bp_vld_cleared", 32'(out_valid), 32'd0);
        send("bp_first", 8'h00, 1'b1, 1'b0, 8'd1);
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_rdy_%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_vld_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_match_%0d", i), 32'(out_match), 32'd1);
            check($sformatf("bp_run_%0d", i), 32'(out_run), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        send("bp_second", 8'h00, 1'b1, 1'b0, 8'd2);
        in_valid = 1'b0;
        check("bp_cnt", 32'(match_count), 32'd2);

        // Key reload in the middle of a run.
        load_key(8'h11);
        send("rl_0", 8'h11, 1'b1, 1'b0, 8'd1);
        send("rl_1", 8'h11, 1'b1, 1'b0, 8'd2);
        key_load = 1'b1;
        key_in   = 8'h22;
        in_valid = 1'b1;
        in_data  = 8'h11;
        #1;
        check("rl_rdy_during_load", 32'(in_ready), 32'd0);
        tick();
        key_load = 1'b0;
        check("rl_not_accepted", 32'(out_valid), 32'd0);
        check("rl_cnt_cleared", 32'(match_count), 32'd0);
        send("rl_new", 8'h22, 1'b1, 1'b0, 8'd1);
        in_valid = 1'b0;
        check("rl_cnt", 32'(match_count), 32'd1);

        // Single-bit discrimination.
        load_key(8'h80);
        send("bit_00", 8'h00, 1'b0, 1'b0, 8'd0);
        send("bit_81", 8'h81, 1'b0, 1'b0, 8'd0);
        send("bit_80", 8'h80, 1'b1, 1'b0, 8'd1);
        in_valid = 1'b0;
        check("bit_cnt", 32'(match_count), 32'd1);

        // Narrow counter saturation.
        s_key_load = 1'b1;
        s_key_in   = 8'h3C;
        tick();
        s_key_load = 1'b0;
        s_in_valid = 1'b1;
        s_in_data  = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("sat_rdy_%0d", i), 32'(s_in_ready), 32'd1);
            tick();
            check($sformatf("sat_cnt_%0d", i), 32'(s_match_count), 32'(sat_cnt[i]));
            check($sformatf("sat_run_%0d", i), 32'(s_out_run), 32'(sat_run[i]));
        end

        // Reset while a beat is held.
        s_out_ready = 1'b0;
        tick();
        check("sat_hold_vld", 32'(s_out_valid), 32'd1);
        check("sat_hold_rdy", 32'(s_in_ready), 32'd0);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_out_ready = 1'b1;
        #1;
        check("rst_vld", 32'(s_out_valid), 32'd0);
        check("rst_cnt", 32'(s_match_count), 32'd0);
        check("rst_run", 32'(s_out_run), 32'd0);
        check("rst_rdy", 32'(s_in_ready), 32'd0);
        tick();
        check("rst_still_unarmed", 32'(s_out_valid), 32'd0);
        s_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
